ring6_decoder: RTL and testbench
================================

RING6_DECODER -- requirements
Module: ring6_decoder

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 clr  input  1  reset, synchronous, active-high.
REQ-003 ring_in  input  6  sampled ring-counter word; bit0=Qa ... bit5=Qf.
REQ-004 ring_vld  input  1  ring_in is valid this cycle; when low, no state, error or counter update.
REQ-005 count  output  3  binary index of the set bit in the last legal accepted sample (Qa=0 ... Qf=5).
REQ-006 locked  output  1  high while the FSM is in LOCK.
REQ-007 wrap  output  1  one-cycle pulse when locked and count advances 5->0.
REQ-008 err_illegal  output  1  one-cycle pulse: valid sample not one-hot (all-zero or more than one bit set).
REQ-009 err_seq  output  1  one-cycle pulse: valid, legal sample that differs from the expected next word, in SYNC or LOCK.
REQ-010 err_cnt  output  8  saturating error tally.

Function
REQ-011 All outputs SHALL be registered and update in the cycle after the ring_vld=1 sample; latency is 1 clk.
REQ-012 Expected next word SHALL be rotate-left of the current word: bit5 wraps to bit0, i.e. Qa->Qb->...->Qf->Qa.
REQ-013 FSM states SHALL be HUNT, SYNC and LOCK; the reset state is HUNT.
REQ-014 HUNT: a legal sample SHALL set expected to its rotation, clear match_cnt and go to SYNC. An illegal sample SHALL stay in HUNT and pulse err_illegal.
REQ-015 SYNC: a sample equal to expected SHALL increment match_cnt. On the 3rd consecutive match (LOCK_MATCHES) the FSM SHALL go to LOCK.
REQ-016 SYNC: any mismatch SHALL go to HUNT and pulse err_seq or err_illegal; the sample is not re-used for hunting.
REQ-017 LOCK: a match SHALL clear miss_cnt.
REQ-018 LOCK: a mismatch SHALL increment miss_cnt, pulse the error, and advance expected from the previous expected word (flywheel); count follows expected.
REQ-019 LOCK: the 2nd consecutive mismatch (LOSS_MISSES) SHALL go to HUNT and deassert locked next cycle.
REQ-020 count SHALL update only on legal accepted samples or flywheel advances; it holds otherwise.
REQ-021 err_cnt SHALL increment by 1 for each cycle with err_illegal or err_seq high, and saturate at 255 with no wrap.
REQ-022 err_illegal and err_seq SHALL be mutually exclusive.
REQ-023 wrap SHALL NOT pulse in HUNT or SYNC.

Reset
REQ-024 clr=1 at a rising edge SHALL force: FSM=HUNT, count=0, locked=0, wrap=0, err_illegal=0, err_seq=0, err_cnt=0, match_cnt=0, miss_cnt=0, expected=6'b000001.
REQ-025 clr SHALL dominate ring_vld in the same cycle; that sample is discarded.
REQ-026 clr asserted mid-LOCK SHALL drop locked on the next edge, with no error pulse.

Structure
REQ-027 Package ring6_pkg SHALL hold: the state enum (HUNT/SYNC/LOCK), RING_W=6, LOCK_MATCHES=3, LOSS_MISSES=2, ERR_CNT_W=8.
REQ-028 Sub-module onehot6_to_bin SHALL be combinational: 6-bit one-hot in, 3-bit index plus legal flag out. It is instantiated once.

Verification
REQ-029 clr=1 for 2 cycles, then valid 000001,000010,000100,001000 -> locked=1 the cycle after the 4th sample, count=3, no errors.
REQ-030 In LOCK, stream through 100000 then 000001 -> wrap=1 for exactly one cycle with count=0.
REQ-031 In LOCK at count=2, inject 000000 once, then resume 010000 -> err_illegal pulse, err_cnt=1, locked stays 1, count 3 then 4.
REQ-032 In LOCK, two consecutive wrong legal words (000001, 000001 when 001000 is expected) -> two err_seq pulses, err_cnt=2, locked=0 after the 2nd.
REQ-033 Hold ring_in=000011 valid for 300 cycles -> err_cnt saturates at 255; FSM stays in HUNT.
REQ-034 Assert clr in the same cycle as a valid 000100 while in LOCK -> all outputs 0 next cycle; the sample is ignored.

Source files
------------

// File: rtl/ring6_pkg.sv
// Shared types and constants for the six-stage ring-counter decoder.
package ring6_pkg;

   localparam int RING_W       = 6;
   localparam int IDX_W        = 3;
   localparam int LOCK_MATCHES = 3;
   localparam int LOSS_MISSES  = 2;
   localparam int ERR_CNT_W    = 8;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      SYNC = 2'd1,
      LOCK = 2'd2
   } state_t;

   // Next ring word: Qf wraps back to Qa.
   function automatic logic [RING_W-1:0] rotl(input logic [RING_W-1:0] w);
      return {w[RING_W-2:0], w[RING_W-1]};
   endfunction

endpackage

// File: rtl/ring6_decoder_if.sv
// Sample stream into the decoder and its registered status back out.
// Handshake: ring_in is consumed on every rising clk edge where ring_vld=1;
// there is no back-pressure, the decoder accepts every valid sample.
interface ring6_decoder_if;
   import ring6_pkg::*;

   logic [RING_W-1:0]    ring_in;
   logic                 ring_vld;
   logic [IDX_W-1:0]     count;
   logic                 locked;
   logic                 wrap;
   logic                 err_illegal;
   logic                 err_seq;
   logic [ERR_CNT_W-1:0] err_cnt;
   state_t               state;

   modport master (
      output ring_in, ring_vld,
      input  count, locked, wrap, err_illegal, err_seq, err_cnt, state
   );

   modport slave (
      input  ring_in, ring_vld,
      output count, locked, wrap, err_illegal, err_seq, err_cnt, state
   );

endinterface

// File: rtl/onehot6_to_bin.sv
// Combinational one-hot to binary index, with a legality flag that is
// low for the all-zero word and for any word with more than one bit set.
module onehot6_to_bin
   import ring6_pkg::*;
(
   input  logic [RING_W-1:0] onehot,
   output logic [IDX_W-1:0]  idx,
   output logic              legal
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < RING_W; i++) begin
         if (onehot[i]) idx = IDX_W'(i);
      end
   end

   assign legal = (onehot != '0) && ((onehot & (onehot - 1'b1)) == '0);

endmodule

// File: rtl/ring6_decoder.sv
// Ring-counter decoder: hunts for a legal word, confirms the rotation,
// then tracks it with a flywheel that rides through isolated bad samples.
module ring6_decoder
   import ring6_pkg::*;
(
   input logic              clk,
   input logic              clr,
   ring6_decoder_if.slave   bus
);

   localparam logic [1:0]           LOCK_LAST = 2'(LOCK_MATCHES - 1);
   localparam logic [1:0]           LOSS_LAST = 2'(LOSS_MISSES - 1);
   localparam logic [IDX_W-1:0]     IDX_MAX   = IDX_W'(RING_W - 1);
   localparam logic [RING_W-1:0]    WORD_RST  = RING_W'(1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

   state_t               state_q, state_d;
   logic [RING_W-1:0]    expected_q, expected_d;
   logic [1:0]           match_q, match_d;
   logic [1:0]           miss_q, miss_d;
   logic [IDX_W-1:0]     count_q, count_d;
   logic                 wrap_q, wrap_d;
   logic                 ei_q, ei_d;
   logic                 es_q, es_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [IDX_W-1:0]     in_idx;
   logic                 in_legal;
   logic                 is_match;
   logic [IDX_W-1:0]     count_next;

   onehot6_to_bin u_dec (
      .onehot (bus.ring_in),
      .idx    (in_idx),
      .legal  (in_legal)
   );

   assign is_match = in_legal && (bus.ring_in == expected_q);
   // While locked, expected is always the rotation of the last counted word.
   assign count_next = (count_q == IDX_MAX) ? '0 : count_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      match_d    = match_q;
      miss_d     = miss_q;
      count_d    = count_q;
      wrap_d     = 1'b0;
      ei_d       = 1'b0;
      es_d       = 1'b0;
      err_cnt_d  = err_cnt_q;

      if (bus.ring_vld) begin
         case (state_q)
            HUNT: begin
               if (in_legal) begin
                  count_d    = in_idx;
                  expected_d = rotl(bus.ring_in);
                  match_d    = '0;
                  state_d    = SYNC;
               end else begin
                  ei_d = 1'b1;
               end
            end
            SYNC: begin
               if (is_match) begin
                  count_d    = in_idx;
                  expected_d = rotl(expected_q);
                  match_d    = match_q + 1'b1;
                  if (match_q == LOCK_LAST) begin
                     state_d = LOCK;
                     miss_d  = '0;
                  end
               end else begin
                  ei_d    = !in_legal;
                  es_d    = in_legal;
                  state_d = HUNT;
               end
            end
            LOCK: begin
               expected_d = rotl(expected_q);
               count_d    = count_next;
               if (is_match) begin
                  miss_d = '0;
               end else begin
                  ei_d = !in_legal;
                  es_d = in_legal;
                  if (miss_q == LOSS_LAST) begin
                     miss_d  = '0;
                     state_d = HUNT;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end
               wrap_d = (count_q == IDX_MAX);
            end
            default: state_d = HUNT;
         endcase

         if ((ei_d || es_d) && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= HUNT;
         expected_q <= WORD_RST;
         match_q    <= '0;
         miss_q     <= '0;
         count_q    <= '0;
         wrap_q     <= 1'b0;
         ei_q       <= 1'b0;
         es_q       <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         count_q    <= count_d;
         wrap_q     <= wrap_d;
         ei_q       <= ei_d;
         es_q       <= es_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign bus.count       = count_q;
   assign bus.locked      = (state_q == LOCK);
   assign bus.wrap        = wrap_q;
   assign bus.err_illegal = ei_q;
   assign bus.err_seq     = es_q;
   assign bus.err_cnt     = err_cnt_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_ring6_decoder.sv
// Bench for ring6_decoder: directed scenarios plus a random ring stream,
// all checked against a position-based model of the decoder rules.
module tb_ring6_decoder;
   import ring6_pkg::*;

   logic clk;
   logic clr;
   ring6_decoder_if bus_if ();

   ring6_decoder dut (
      .clk (clk),
      .clr (clr),
      .bus (bus_if)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: positions 0..5 instead of words; mode 0=hunting 1=confirming 2=tracking
   int m_mode, m_next, m_seen, m_bad_run, m_pos, m_errs;
   bit m_wrap, m_ill, m_seq;

   // scoreboard
   logic [14:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] dut_word();
      return {bus_if.locked, bus_if.wrap, bus_if.err_illegal, bus_if.err_seq,
              bus_if.count, bus_if.err_cnt};
   endfunction

   task automatic model_step(input logic [5:0] ring, input bit vld, input bit rst);
      int  pos;
      bit  legal;
      bit  hit;
      int  old_pos;
      m_wrap = 0; m_ill = 0; m_seq = 0;
      if (rst) begin
         m_mode = 0; m_next = 0; m_seen = 0; m_bad_run = 0; m_pos = 0; m_errs = 0;
         return;
      end
      if (!vld) return;
      legal = ($countones(ring) == 1);
      pos = 0;
      for (int i = 0; i < 6; i++) if (ring[i]) pos = i;
      hit = legal && (pos == m_next);
      old_pos = m_pos;
      if (m_mode == 0) begin
         if (legal) begin
            m_pos = pos; m_next = (pos + 1) % 6; m_seen = 0; m_mode = 1;
         end else m_ill = 1;
      end else if (m_mode == 1) begin
         if (hit) begin
            m_seen++; m_pos = pos; m_next = (pos + 1) % 6;
            if (m_seen == 3) begin m_mode = 2; m_bad_run = 0; end
         end else begin
            m_ill = !legal; m_seq = legal; m_mode = 0;
         end
      end else begin
         // tracking: position advances whether or not the sample agreed
         m_pos = m_next; m_next = (m_next + 1) % 6;
         if (hit) m_bad_run = 0;
         else begin
            m_ill = !legal; m_seq = legal; m_bad_run++;
            if (m_bad_run == 2) begin m_mode = 0; m_bad_run = 0; end
         end
         m_wrap = (old_pos == 5) && (m_pos == 0);
      end
      if ((m_ill || m_seq) && m_errs < 255) m_errs++;
   endtask

   // driver
   task automatic step(input logic [5:0] ring, input bit vld, input bit rst);
      logic [14:0] e;
      bus_if.ring_in  = ring;
      bus_if.ring_vld = vld;
      clr             = rst;
      model_step(ring, vld, rst);
      e = {(m_mode == 2) ? 1'b1 : 1'b0, m_wrap, m_ill, m_seq, 3'(m_pos), 8'(m_errs)};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check("cycle", 32'(dut_word()), 32'(exp_q.pop_front()));
   endtask

   task automatic lock_from(input int start);
      for (int i = 0; i < 4; i++) step(6'(1 << ((start + i) % 6)), 1, 0);
   endtask

   initial begin
      int p;
      int r;
      logic [5:0] bad_words[4];
      bad_words[0] = 6'h00; bad_words[1] = 6'h03; bad_words[2] = 6'h3f; bad_words[3] = 6'h21;
      clr = 1'b1;
      bus_if.ring_in  = '0;
      bus_if.ring_vld = 1'b0;
      @(posedge clk);
      #1;

      // reset and first lock
      step(6'h00, 0, 1);
      step(6'h00, 0, 1);
      check("rst_count", 32'(bus_if.count), 0);
      check("rst_state", 32'(bus_if.state), 32'(HUNT));
      lock_from(0);
      check("lock_locked", 32'(bus_if.locked), 1);
      check("lock_count", 32'(bus_if.count), 3);
      check("lock_errs", 32'(bus_if.err_cnt), 0);

      // wrap
      step(6'h10, 1, 0);
      step(6'h20, 1, 0);
      step(6'h01, 1, 0);
      check("wrap_pulse", 32'(bus_if.wrap), 1);
      check("wrap_count", 32'(bus_if.count), 0);
      step(6'h02, 1, 0);
      check("wrap_once", 32'(bus_if.wrap), 0);
      step(6'h04, 1, 0);

      // illegal word rides the flywheel
      step(6'h00, 1, 0);
      check("ill_pulse", 32'(bus_if.err_illegal), 1);
      check("ill_errs", 32'(bus_if.err_cnt), 1);
      check("ill_locked", 32'(bus_if.locked), 1);
      check("ill_count", 32'(bus_if.count), 3);
      step(6'h10, 1, 0);
      check("ill_resume", 32'(bus_if.count), 4);

      // two sequence errors lose lock
      step(6'h00, 0, 1);
      lock_from(5);
      check("seq_pre_count", 32'(bus_if.count), 2);
      step(6'h01, 1, 0);
      check("seq1_pulse", 32'(bus_if.err_seq), 1);
      check("seq1_locked", 32'(bus_if.locked), 1);
      step(6'h01, 1, 0);
      check("seq2_pulse", 32'(bus_if.err_seq), 1);
      check("seq2_errs", 32'(bus_if.err_cnt), 2);
      check("seq2_locked", 32'(bus_if.locked), 0);

      // saturation
      step(6'h00, 0, 1);
      for (int i = 0; i < 300; i++) step(6'h03, 1, 0);
      check("sat_errs", 32'(bus_if.err_cnt), 255);
      check("sat_state", 32'(bus_if.state), 32'(HUNT));

      // clear beats a valid sample while locked
      step(6'h00, 0, 1);
      lock_from(0);
      step(6'h04, 1, 1);
      check("clr_word", 32'(dut_word()), 0);
      check("clr_state", 32'(bus_if.state), 32'(HUNT));

      // random ring stream with dropouts, glitches and misalignments
      r = 0;
      for (int i = 0; i < 600; i++) begin
         p = $urandom_range(0, 99);
         if (p < 3) step(6'h00, $urandom_range(0, 1), 1);
         else if (p < 15) step(6'($urandom_range(0, 63)), 0, 0);
         else if (p < 22) step(bad_words[$urandom_range(0, 3)], 1, 0);
         else if (p < 28) begin
            r = $urandom_range(0, 5);
            step(6'(1 << r), 1, 0);
            r = (r + 1) % 6;
         end else begin
            step(6'(1 << r), 1, 0);
            r = (r + 1) % 6;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
